alu_result_formatter: RTL and testbench

Consumer end of the ALU result/flag interface. It captures one 16-bit ALU result plus its Z/N/C/O flags over a valid/ready handshake. It converts the result to 5 BCD digits sequentially (shift-and-add-3, one bit per cycle), then presents the digits, a sign, a zero indicator, an error indicator and a leading-zero blank mask to the calculator display driver over a second valid/ready handshake.

---
 rtl/calc_pkg.sv | 16 +
 rtl/alu_result_formatter_bcd_add3.sv | 11 +
 rtl/alu_result_formatter.sv | 163 ++++++++++++++++
 tb/tb_alu_result_formatter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the ALU result formatter.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    BLANK   = 2'd2,
    HOLD    = 2'd3
  } fmt_state_t;

  localparam int          RES_W       = 16;
  localparam int          BCD_DIGITS  = 5;
  localparam int          BCD_W       = 20;
  localparam logic [3:0]  ADD3_THRESH = 4'd5;

endpackage

// File: rtl/alu_result_formatter_bcd_add3.sv
// One BCD digit correction step of the shift-and-add-3 converter.
module bcd_add3
  import calc_pkg::*;
(
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);

  assign d_out = (d_in >= ADD3_THRESH) ? d_in + 4'd3 : d_in;

endmodule

// File: rtl/alu_result_formatter.sv
// Captures an ALU result with flags, converts it to 5 BCD digits serially,
// and hands digits, sign, zero/error flags and leading-zero mask to the display.
//
// state   | meaning
// IDLE    | waiting for an ALU result, in_ready high
// CONVERT | 16 shift-and-add-3 iterations
// BLANK   | publish digits and leading-zero mask
// HOLD    | out_valid high until display driver accepts
module alu_result_formatter
  import calc_pkg::*;
#(
  parameter bit SIGNED_DISPLAY = 1'b1,
  parameter bit ERR_ON_CARRY   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_result,
  input  logic             in_z,
  input  logic             in_n,
  input  logic             in_c,
  input  logic             in_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BCD_W-1:0] out_bcd,
  output logic [4:0]       out_blank,
  output logic             out_neg,
  output logic             out_zero,
  output logic             out_err
);

  fmt_state_t state_q, state_d;

  logic [RES_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BCD_W-1:0] out_bcd_q, out_bcd_d;
  logic [4:0]       out_blank_q, out_blank_d;
  logic             out_neg_q, out_neg_d;
  logic             out_zero_q, out_zero_d;
  logic             out_err_q, out_err_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             use_neg;
  logic [RES_W-1:0] magnitude;
  logic [BCD_W-1:0] bcd_adj;
  logic [4:0]       blank_mask;

  assign accept  = in_valid && (state_q == IDLE);
  assign use_neg = SIGNED_DISPLAY && in_n;
  // 16-bit negate: 0x8000 maps to itself, which reads as 32768 unsigned
  assign magnitude = use_neg ? (~in_result + 16'd1) : in_result;

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .d_in  (bcd_q[4*i +: 4]),
      .d_out (bcd_adj[4*i +: 4])
    );
  end

  always_comb begin
    blank_mask    = 5'b00000;
    blank_mask[4] = (bcd_q[19:16] == 4'd0);
    for (int k = 3; k >= 1; k--) begin
      blank_mask[k] = blank_mask[k+1] && (bcd_q[4*k +: 4] == 4'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CONVERT;
      CONVERT: if (cnt_q == 4'd15) state_d = BLANK;
      BLANK:   state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
  end

  always_comb begin
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    out_bcd_d   = out_bcd_q;
    out_blank_d = out_blank_q;
    out_neg_d   = out_neg_q;
    out_zero_d  = out_zero_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          bin_d      = magnitude;
          bcd_d      = '0;
          cnt_d      = 4'd0;
          out_zero_d = in_z;
          out_err_d  = ERR_ON_CARRY ? (in_c | in_o) : in_o;
          out_neg_d  = use_neg;
        end
      end
      CONVERT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[RES_W-1]};
        bin_d = {bin_q[RES_W-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
      end
      BLANK: begin
        out_bcd_d   = bcd_q;
        out_blank_d = blank_mask;
        out_valid_d = 1'b1;
      end
      HOLD: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      out_bcd_q   <= '0;
      out_blank_q <= '0;
      out_neg_q   <= 1'b0;
      out_zero_q  <= 1'b0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      out_bcd_q   <= out_bcd_d;
      out_blank_q <= out_blank_d;
      out_neg_q   <= out_neg_d;
      out_zero_q  <= out_zero_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign out_blank = out_blank_q;
  assign out_neg   = out_neg_q;
  assign out_zero  = out_zero_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_alu_result_formatter.sv
// Bench for alu_result_formatter: default build and an unsigned/no-carry-error build share inputs.
module tb_alu_result_formatter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_z, in_n, in_c, in_o, out_ready;
  logic [15:0] in_result;

  logic        in_ready_s, out_valid_s, out_neg_s, out_zero_s, out_err_s;
  logic [19:0] out_bcd_s;
  logic [4:0]  out_blank_s;
  logic        in_ready_u, out_valid_u, out_neg_u, out_zero_u, out_err_u;
  logic [19:0] out_bcd_u;
  logic [4:0]  out_blank_u;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_result_formatter #(.SIGNED_DISPLAY(1'b1), .ERR_ON_CARRY(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_result(in_result), .in_z(in_z), .in_n(in_n), .in_c(in_c), .in_o(in_o),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_bcd(out_bcd_s),
    .out_blank(out_blank_s), .out_neg(out_neg_s), .out_zero(out_zero_s), .out_err(out_err_s)
  );

  alu_result_formatter #(.SIGNED_DISPLAY(1'b0), .ERR_ON_CARRY(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_result(in_result), .in_z(in_z), .in_n(in_n), .in_c(in_c), .in_o(in_o),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_bcd(out_bcd_u),
    .out_blank(out_blank_u), .out_neg(out_neg_u), .out_zero(out_zero_u), .out_err(out_err_u)
  );

  // Reference: decimal digits by division, blank mask by scanning from the top digit.
  function automatic logic [27:0] model(input int r, input bit z, input bit n, input bit c,
                                        input bit o, input bit sgn, input bit ec);
    int          mag;
    int          v;
    bit          lead;
    logic [19:0] bcd;
    logic [4:0]  blank;
    mag = (sgn && n) ? (65536 - r) % 65536 : r;
    v = mag;
    bcd = '0;
    for (int k = 0; k < 5; k++) begin
      bcd[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    blank = '0;
    lead = 1'b1;
    for (int k = 4; k >= 1; k--) begin
      if (bcd[4*k +: 4] != 4'd0) lead = 1'b0;
      blank[k] = lead;
    end
    return {bcd, blank, sgn && n, z, ec ? (c | o) : o};
  endfunction

  function automatic logic [27:0] got_s();
    return {out_bcd_s, out_blank_s, out_neg_s, out_zero_s, out_err_s};
  endfunction

  function automatic logic [27:0] got_u();
    return {out_bcd_u, out_blank_u, out_neg_u, out_zero_u, out_err_u};
  endfunction

  task automatic accept(input logic [15:0] r, input bit z, input bit n, input bit c, input bit o);
    @(negedge clk);
    in_result = r; in_z = z; in_n = n; in_c = c; in_o = o;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Bounded wait: returns negedges elapsed until out_valid of the signed build is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid_s && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    in_result = '0; in_z = 0; in_n = 0; in_c = 0; in_o = 0;
    #1;
    checks++;
    if ({got_s(), out_valid_s, got_u(), out_valid_u} !== '0 || in_ready_s !== 1'b1 || in_ready_u !== 1'b1) begin
      errors++;
      $display("FAIL reset_during: outs_s=%h outs_u=%h ready=%b%b required outs=0 ready=11",
               {got_s(), out_valid_s}, {got_u(), out_valid_u}, in_ready_s, in_ready_u);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({got_s(), out_valid_s, got_u(), out_valid_u} !== '0 || in_ready_s !== 1'b1 || in_ready_u !== 1'b1) begin
      errors++;
      $display("FAIL reset_after: outs_s=%h outs_u=%h ready=%b%b required outs=0 ready=11",
               {got_s(), out_valid_s}, {got_u(), out_valid_u}, in_ready_s, in_ready_u);
    end
  endtask

  task automatic run_one(input string tag, input logic [15:0] r, input bit z, input bit n,
                         input bit c, input bit o, input int ready_delay);
    int          lat;
    logic [27:0] exp_s, exp_u;
    exp_s = model(int'(r), z, n, c, o, 1'b1, 1'b1);
    exp_u = model(int'(r), z, n, c, o, 1'b0, 1'b0);
    accept(r, z, n, c, o);
    wait_valid(lat);
    checks++;
    if (lat != 17 || out_valid_u !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles (valid_u=%b) required 17 (valid_u=1)", tag, lat, out_valid_u);
    end
    checks++;
    if (got_s() !== exp_s) begin
      errors++;
      $display("FAIL %s_signed: in=%h got {bcd,blank,neg,zero,err}=%h required %h", tag, r, got_s(), exp_s);
    end
    checks++;
    if (got_u() !== exp_u) begin
      errors++;
      $display("FAIL %s_unsigned: in=%h got {bcd,blank,neg,zero,err}=%h required %h", tag, r, got_u(), exp_u);
    end
    repeat (ready_delay) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1 || out_valid_u !== 1'b0 || got_s() !== exp_s) begin
      errors++;
      $display("FAIL %s_release: valid=%b ready=%b valid_u=%b outs=%h required valid=0 ready=1 valid_u=0 outs=%h",
               tag, out_valid_s, in_ready_s, out_valid_u, got_s(), exp_s);
    end
  endtask

  task automatic test_directed();
    logic [15:0] vr [5] = '{16'd1234, 16'hFFFF, 16'hFFF6, 16'h8000, 16'h0000};
    bit          vz [5] = '{0, 0, 0, 0, 1};
    bit          vn [5] = '{0, 0, 1, 1, 0};
    bit          vc [5] = '{0, 0, 0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      run_one($sformatf("dir%0d", i), vr[i], vz[i], vn[i], vc[i], 1'b0, 0);
    end
  endtask

  task automatic test_random();
    logic [15:0] r;
    for (int i = 0; i < 20; i++) begin
      r = 16'($urandom);
      if (i % 5 == 0) r = 16'($urandom_range(0, 99));
      run_one($sformatf("rnd%0d", i), r, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic [27:0] exp_a, exp_b;
    exp_a = model(777, 0, 0, 0, 0, 1'b1, 1'b1);
    exp_b = model(999, 0, 0, 0, 1, 1'b1, 1'b1);
    accept(16'd777, 0, 0, 0, 0);
    wait_valid(lat);
    checks++;
    if (lat != 17) begin
      errors++;
      $display("FAIL hold_latency: got %0d cycles required 17", lat);
    end
    in_result = 16'd999; in_o = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid_s !== 1'b1 || in_ready_s !== 1'b0 || in_ready_u !== 1'b0 || got_s() !== exp_a) begin
        errors++;
        $display("FAIL hold_stable%0d: valid=%b ready=%b%b outs=%h required valid=1 ready=00 outs=%h",
                 i, out_valid_s, in_ready_s, in_ready_u, got_s(), exp_a);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: valid=%b ready=%b required valid=0 ready=1", out_valid_s, in_ready_s);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_o = 1'b0;
    wait_valid(lat);
    checks++;
    if (lat != 17 || got_s() !== exp_b) begin
      errors++;
      $display("FAIL hold_next: lat=%0d outs=%h required lat=17 outs=%h", lat, got_s(), exp_b);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int          lat;
    bit          seen;
    logic [27:0] exp_c;
    accept(16'hFFF6, 0, 1, 1, 1);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({got_s(), out_valid_s, got_u(), out_valid_u} !== '0 || in_ready_s !== 1'b1 || in_ready_u !== 1'b1) begin
      errors++;
      $display("FAIL midreset_clear: outs_s=%h outs_u=%h ready=%b%b required outs=0 ready=11",
               {got_s(), out_valid_s}, {got_u(), out_valid_u}, in_ready_s, in_ready_u);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid_s || out_valid_u) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midreset_novalid: out_valid pulsed=1 required 0");
    end
    exp_c = model(42, 0, 0, 0, 0, 1'b1, 1'b1);
    accept(16'd42, 0, 0, 0, 0);
    wait_valid(lat);
    checks++;
    if (lat != 17 || got_s() !== exp_c || out_bcd_u !== 20'h00042) begin
      errors++;
      $display("FAIL midreset_42: lat=%0d outs=%h bcd_u=%h required lat=17 outs=%h bcd_u=00042",
               lat, got_s(), out_bcd_u, exp_c);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
